// File: rtl/ifid_pkg.sv
// ifid_pkg: shared constants for the IF/ID pipeline register.
// Holds MIPS field positions, instruction width and opcode values.
package ifid_pkg;

  localparam int INSTR_W  = 32;

  localparam int OP_LSB     = 26;
  localparam int OP_W       = 6;
  localparam int RS_LSB     = 21;
  localparam int RS_W       = 5;
  localparam int RT_LSB     = 16;
  localparam int RT_W       = 5;
  localparam int RD_LSB     = 11;
  localparam int RD_W       = 5;
  localparam int SHAMT_LSB  = 6;
  localparam int SHAMT_W    = 5;
  localparam int FUNC_LSB   = 0;
  localparam int FUNC_W     = 6;
  localparam int IMM_LSB    = 0;
  localparam int IMM_W      = 16;
  localparam int TARGET_LSB = 0;
  localparam int TARGET_W   = 26;

  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;

endpackage

// File: rtl/ifid_skid_buf.sv
// ifid_skid_buf: generic 2-entry valid/ready skid buffer with flush.
// Main entry drives the outputs; skid entry absorbs one word on stall.
module ifid_skid_buf #(
  parameter int         W        = 64,
  parameter logic [W-1:0] RST_DATA = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_v, main_v_n;
  logic         skid_v, skid_v_n;
  logic [W-1:0] main_d, main_d_n;
  logic [W-1:0] skid_d, skid_d_n;
  logic         acc;
  logic         pop;

  assign in_ready  = !skid_v;
  assign out_valid = main_v;
  assign out_data  = main_d;

  assign acc = in_valid && !skid_v;
  assign pop = main_v && out_ready;

  // next-state for both entries; flush clears valids but keeps data
  always_comb begin
    main_v_n = main_v;
    main_d_n = main_d;
    skid_v_n = skid_v;
    skid_d_n = skid_d;
    if (flush) begin
      main_v_n = 1'b0;
      skid_v_n = 1'b0;
    end else if (!main_v || pop) begin
      if (skid_v) begin
        main_v_n = 1'b1;
        main_d_n = skid_d;
        skid_v_n = acc;
        if (acc) skid_d_n = in_data;
      end else begin
        main_v_n = acc;
        if (acc) main_d_n = in_data;
      end
    end else if (acc) begin
      skid_v_n = 1'b1;
      skid_d_n = in_data;
    end
  end

  // entry registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_d <= RST_DATA;
      skid_d <= RST_DATA;
    end else begin
      main_v <= main_v_n;
      skid_v <= skid_v_n;
      main_d <= main_d_n;
      skid_d <= skid_d_n;
    end
  end

endmodule

// File: rtl/ifid_pipe_reg.sv
// ifid_pipe_reg: IF/ID register with skid buffer and MIPS field decode.
// Define IFID_PERF_CNT_EN to add bubble_cnt/stall_cnt counters.
module ifid_pipe_reg
  import ifid_pkg::*;
#(
  parameter int               PC_W      = 32,
  parameter int               IMM_EXT_W = 32,
  parameter logic [PC_W-1:0]  RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [INSTR_W-1:0]   in_instr,
  input  logic [PC_W-1:0]      in_pc,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OP_W-1:0]      out_op,
  output logic [RS_W-1:0]      out_rs,
  output logic [RT_W-1:0]      out_rt,
  output logic [RD_W-1:0]      out_rd,
  output logic [SHAMT_W-1:0]   out_shamt,
  output logic [FUNC_W-1:0]    out_func,
  output logic [IMM_W-1:0]     out_imm,
  output logic [IMM_EXT_W-1:0] out_imm_sext,
  output logic [TARGET_W-1:0]  out_target,
  output logic [PC_W-1:0]      out_pc
`ifdef IFID_PERF_CNT_EN
  ,
  output logic [31:0]          bubble_cnt,
  output logic [31:0]          stall_cnt
`endif
);

  localparam int DW = INSTR_W + PC_W;
  localparam logic [DW-1:0] RST_DATA = {NOP, RESET_PC};

  logic [DW-1:0]      q_data;
  logic [INSTR_W-1:0] instr;

  ifid_skid_buf #(
    .W        (DW),
    .RST_DATA (RST_DATA)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({in_instr, in_pc}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (q_data)
  );

  assign instr  = q_data[PC_W +: INSTR_W];
  assign out_pc = q_data[PC_W-1:0];

  assign out_op     = instr[OP_LSB +: OP_W];
  assign out_rs     = instr[RS_LSB +: RS_W];
  assign out_rt     = instr[RT_LSB +: RT_W];
  assign out_rd     = instr[RD_LSB +: RD_W];
  assign out_shamt  = instr[SHAMT_LSB +: SHAMT_W];
  assign out_func   = instr[FUNC_LSB +: FUNC_W];
  assign out_imm    = instr[IMM_LSB +: IMM_W];
  assign out_target = instr[TARGET_LSB +: TARGET_W];

  if (IMM_EXT_W > IMM_W) begin : g_sext
    assign out_imm_sext = {{(IMM_EXT_W-IMM_W){out_imm[IMM_W-1]}}, out_imm};
  end else begin : g_nosext
    assign out_imm_sext = out_imm;
  end

`ifdef IFID_PERF_CNT_EN
  // count decode-side bubbles and stalls; only reset clears them
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (out_ready && !out_valid) bubble_cnt <= bubble_cnt + 32'd1;
      if (out_valid && !out_ready) stall_cnt  <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/ifid_pipe_reg.md
Name: ifid_pipe_reg

Overview:
Parametrised IF/ID pipeline register for the mini-CPU pipeline.
- Accepts a fetched instruction word plus its PC from the fetch stage over a valid/ready handshake.
- Buffers it in a 2-entry skid buffer, so that a decode-side stall never loses a fetched word and in_ready is registered.
- Presents decoded MIPS-format fields (op, rs, rt, rd, shamt, func, imm, sign-extended imm, jump target) to the decode stage.
- Supports a one-cycle flush for branch/jump redirect.

Parameters:
PC_W, 32, width of the program-counter field carried alongside the instruction
IMM_EXT_W, 32, width of the sign-extended immediate output (must be >= 16)
RESET_PC, 0, value loaded into out_pc on reset

Ports:
clk  in  1  pipeline clock, all state updates on posedge
rst  in  1  synchronous, active-high reset
in_valid  in  1  fetch stage presents a valid instruction
in_ready  out  1  block can accept a word this cycle (registered)
in_instr  in  32  fetched instruction word
in_pc  in  PC_W  PC of in_instr
flush  in  1  discard all buffered and incoming words (redirect)
out_valid  out  1  decoded fields hold a valid instruction
out_ready  in  1  decode stage accepts the current word
out_op  out  6  instr[31:26]
out_rs  out  5  instr[25:21]
out_rt  out  5  instr[20:16]
out_rd  out  5  instr[15:11]
out_shamt  out  5  instr[10:6]
out_func  out  6  instr[5:0]
out_imm  out  16  instr[15:0]
out_imm_sext  out  IMM_EXT_W  instr[15:0] sign-extended
out_target  out  26  instr[25:0]
out_pc  out  PC_W  PC of the presented instruction

Behaviour:
- Storage: main entry (drives outputs) and skid entry, each holding {valid, instr, pc}. All outputs are registered from the main entry; there is no combinational path from input to output.
- Reset (rst=1 at posedge):
  - Both valids clear; in_ready=1; out_valid=0.
  - All field outputs = 0; out_pc = RESET_PC.
  - Reset mid-transfer drops any word in flight.
- Accept: a word is accepted when in_valid && in_ready. Pop: a word is popped when out_valid && out_ready.
- Latency: an accepted word appears on the outputs in the next cycle if the main entry is empty or being popped.
- Next-state, no flush:
  - Main empty or popping: main loads skid if skid is valid (skid then loads the accepted word, if any, else clears); otherwise main loads the accepted word.
  - Main full and not popping: an accepted word goes to skid.
- in_ready (next) = !skid_valid(next). It deasserts only when both entries are full.
- Flush is 1-cycle and takes priority over accept and pop:
  - Both valids clear next cycle.
  - The incoming word in the same cycle is dropped, even if in_ready=1.
  - in_ready=1 next cycle.
  - Field outputs and out_pc hold their last value.
- Simultaneous pop and accept with skid empty: main reloads from the input (full throughput, 1 word/cycle).
- Simultaneous flush and rst: reset wins (same outcome).
- When out_valid=0, field outputs hold their last loaded value; consumers must qualify them with out_valid.
- Sign extension: out_imm_sext = {(IMM_EXT_W-16){instr[15]}, instr[15:0]}.

Optional Feature:
IFID_PERF_CNT_EN
- Defined: adds outputs bubble_cnt[31:0] and stall_cnt[31:0].
  - bubble_cnt increments on cycles with out_ready && !out_valid.
  - stall_cnt increments on cycles with out_valid && !out_ready.
  - Both cleared by rst, not by flush, and wrap at 2^32.
- Undefined: neither port nor any counter logic exists.

Decomposition:
- Package ifid_pkg holds:
  - Field bit positions and widths (OP, RS, RT, RD, SHAMT, FUNC, IMM, TARGET).
  - INSTR_W=32.
  - NOP encoding 32'h0000_0000.
  - Opcode constants used by the bench (R-type 6'h00, J 6'h02, BEQ 6'h04, ADDI 6'h08).
- One sub-module, ifid_skid_buf: a generic 2-entry valid/ready skid buffer with flush, parametrised on payload width (32+PC_W). Field slicing and sign extension stay in the top level.

Test Plan:
- Reset: rst=1 for 2 cycles -> out_valid=0, in_ready=1, all fields 0, out_pc=RESET_PC.
- Streaming with out_ready=1: push instr 32'h2008_FFFF at pc 0x100 -> next cycle out_op=6'h08, out_rt=5'd8, out_imm=16'hFFFF, out_imm_sext=32'hFFFF_FFFF, out_pc=0x100. Four back-to-back words arrive on four consecutive cycles.
- Stall: hold out_ready=0 while pushing 3 words -> in_ready drops after the 2nd is accepted. Release out_ready -> words emerge in order with none lost or duplicated.
- Flush: flush=1 with both entries full and in_valid=1 -> next cycle out_valid=0, in_ready=1. The incoming word never appears at the outputs.
- R-type decode: instr 32'h0123_4820 (add $9,$9,$3) -> out_op=0, out_rs=9, out_rt=3, out_rd=9, out_shamt=0, out_func=6'h20.
- IFID_PERF_CNT_EN: 3 idle cycles with out_ready=1, then 2 stalled cycles -> bubble_cnt=3, stall_cnt=2. A flush leaves both counts unchanged.
